pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline-stage register, successor to the fixed EX/MEM latch.
- Carries an opaque packed payload with a valid/ready handshake instead of a bare stall.
- Adds an optional 2-entry skid buffer so upstream ready is fully registered, plus a synchronous flush.
- Drops between any two core stages (ID/EX, EX/MEM, MEM/WB); the instantiating stage packs and unpacks the payload.

Parameters:
- PAYLOAD_W, 144, payload width in bits (EX/MEM packing: result 64 + waddr 5 + wen 1 + mem_valid 1 + mem_rw 1 + mem_data 64 + byte_valid 8 = 144); legal range 1..1024.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept
- in_payload  in  PAYLOAD_W  upstream payload
- out_valid  out  1  main entry holds data
- out_ready  in  1  downstream accepts
- out_payload  out  PAYLOAD_W  main entry payload
- stall  in  1  global freeze from hazard unit
- flush  in  1  discard all held and incoming data
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset value of every state element and output: out_valid 0, out_payload 0, skid entry and skid valid 0, occupancy 0. in_ready is 0 while rst=1.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready & !stall.
- Payload rules:
  - Payload is captured only on push.
  - out_payload is held stable while out_valid=1 and no pop occurs.
  - Payload contents are never modified or inspected.
- SKID=1 state machine (EMPTY / ONE / TWO), one transition per clk:
  - EMPTY: push -> ONE, main <= in_payload.
  - ONE: push & pop -> ONE, main <= in_payload. push & !pop -> TWO, skid <= in_payload. !push & pop -> EMPTY. Otherwise hold.
  - TWO: pop -> ONE, main <= skid, skid cleared. Otherwise hold.
- SKID=1 ready: in_ready = (state != TWO) & !stall & !flush & !rst. The state term comes from a flop, so there is no combinational path from out_ready to in_ready.
- SKID=0:
  - States EMPTY / ONE only.
  - in_ready = (!out_valid | out_ready) & !stall & !flush & !rst, a combinational path from out_ready.
  - push loads main; pop without push empties main.
- stall=1:
  - No push and no pop; state and payloads frozen.
  - out_valid keeps its current value.
  - Downstream must qualify with stall; pop already does this internally.
- flush=1:
  - Next state EMPTY.
  - out_valid 0, skid valid 0, occupancy 0 after the edge.
  - Incoming payload is discarded; in_ready is forced 0 that cycle.
  - Payload registers are not cleared; contents are don't-care when invalid.
  - Priority: rst > flush > stall > handshake.
- Latency:
  - 1 cycle from push to out_valid when empty.
  - Throughput is 1 transfer per cycle with out_ready held at 1.
  - No bubbles inserted in either SKID mode.
- Ordering: strict FIFO. The skid entry is always older than anything pushed later, and it moves to main before any newer payload.
- Reset mid-operation: held entries are dropped; the next cycle is EMPTY with in_ready=1 if stall=0 and flush=0.
- Occupancy equals 0 / 1 / 2 for EMPTY / ONE / TWO.

Test Plan:
- Reset then stream: rst 2 cycles; drive payloads 0x1,0x2,0x3 back-to-back with out_ready=1 -> out_valid from cycle 1, out_payload 0x1,0x2,0x3 on consecutive cycles, occupancy stays 1, no gaps.
- Backpressure (SKID=1): out_ready=0 while pushing 0xA, 0xB. Required:
  - occupancy 1 then 2.
  - in_ready=0 on the cycle after the second push.
  - A third in_valid with 0xC is held off.
  - After release, out_payload reads 0xA,0xB,0xC in order.
- Stall: with TWO entries held, assert stall 3 cycles while out_ready=1 -> occupancy stays 2, out_payload stays 0xA, in_ready=0; on release drain resumes in order.
- Flush with simultaneous push: occupancy 2, flush=1 and in_valid=1 with 0xD same cycle -> next cycle out_valid=0, occupancy 0, 0xD never appears at the output.
- SKID=0 mode: out_ready toggling 1,0,1 under continuous in_valid -> in_ready mirrors out_ready combinationally while full, occupancy never exceeds 1, all payloads delivered once.
- Reset mid-operation: rst asserted with occupancy 2 -> next cycle out_valid=0, occupancy 0, out_payload 0; first push afterwards appears 1 cycle later.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - pipeline stage register with valid/ready handshake and optional skid entry
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_payload captured on push
//   out_valid/out_ready   downstream handshake; out_payload is the main entry
//   stall                 freezes state (no push, no pop)
//   flush                 empties the stage; incoming data is discarded
//   occupancy             number of held entries (0..2)
module pipe_skid_stage #(
  parameter int unsigned PAYLOAD_W = 144,
  parameter int unsigned SKID      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 stall,
  input  logic                 flush,
  output logic [1:0]           occupancy
);

  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;

  logic space_ok;
  logic push;
  logic pop;

  // With the skid entry, readiness depends only on flopped state so the
  // upstream ready path is isolated from out_ready. Without it, a full main
  // entry can still accept when it is being drained this cycle.
  always_comb begin
    if (SKID != 0) begin
      space_ok = !skid_valid_q;
    end else begin
      space_ok = !main_valid_q || out_ready;
    end
  end

  assign in_ready = space_ok && !stall && !flush && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready && !stall;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (flush) begin
      // Payload registers keep stale contents; only the valid bits matter.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // TWO: in_ready is low, so the only event is a pop promoting the
      // older skid entry into main.
      if (pop) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
        skid_d       = '0;
      end
    end else if (main_valid_q) begin
      if (push && pop) begin
        main_d = in_payload;
      end else if (push) begin
        // Only reachable with SKID != 0: in the single-register mode a push
        // into a full main entry implies a simultaneous pop.
        skid_valid_d = 1'b1;
        skid_d       = in_payload;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      main_valid_d = 1'b1;
      main_d       = in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_payload = main_q;
  assign occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - randomized and directed checks of pipe_skid_stage in both skid modes
module tb_pipe_skid_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, stall, flush;
  logic [W-1:0] in_payload;

  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0] out_payload1, out_payload0;
  logic [1:0]   occupancy1, occupancy0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.PAYLOAD_W(W), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_payload(in_payload), .out_valid(out_valid1), .out_ready(out_ready),
    .out_payload(out_payload1), .stall(stall), .flush(flush), .occupancy(occupancy1)
  );

  pipe_skid_stage #(.PAYLOAD_W(W), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_payload(in_payload), .out_valid(out_valid0), .out_ready(out_ready),
    .out_payload(out_payload0), .stall(stall), .flush(flush), .occupancy(occupancy0)
  );

  // Reference model: index 0 = SKID 1 (capacity 2), index 1 = SKID 0 (capacity 1).
  int           cnt[2];
  logic [W-1:0] mpay[2][2];
  bit           rzero[2];
  bit           started = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int u);
    bit room;
    room = (u == 0) ? (cnt[u] < 2) : (cnt[u] == 0 || out_ready);
    return room && !rst && !stall && !flush;
  endfunction

  always @(posedge clk) begin
    if (rst) started = 1;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        cnt[u]   = 0;
        rzero[u] = 1;
      end else if (flush) begin
        cnt[u] = 0;
      end else begin
        bit do_push, do_pop;
        do_push = in_valid && exp_ready(u);
        do_pop  = cnt[u] > 0 && out_ready && !stall;
        if (do_pop) begin
          mpay[u][0] = mpay[u][1];
          cnt[u]--;
        end
        if (do_push) begin
          mpay[u][cnt[u]] = in_payload;
          cnt[u]++;
          rzero[u] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        logic         a_ir, a_ov;
        logic [1:0]   a_oc;
        logic [W-1:0] a_op;
        a_ir = (u == 0) ? in_ready1    : in_ready0;
        a_ov = (u == 0) ? out_valid1   : out_valid0;
        a_oc = (u == 0) ? occupancy1   : occupancy0;
        a_op = (u == 0) ? out_payload1 : out_payload0;
        chk($sformatf("model_in_ready[%0d]", u), {31'd0, a_ir}, {31'd0, exp_ready(u)});
        chk($sformatf("model_out_valid[%0d]", u), {31'd0, a_ov}, {31'd0, cnt[u] > 0});
        chk($sformatf("model_occupancy[%0d]", u), {30'd0, a_oc}, cnt[u]);
        if (cnt[u] > 0) chk($sformatf("model_payload[%0d]", u), a_op, mpay[u][0]);
        else if (rzero[u]) chk($sformatf("model_reset_payload[%0d]", u), a_op, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pat[5];
    rst = 1; in_valid = 0; out_ready = 0; stall = 0; flush = 0; in_payload = '0;
    tick(); tick();
    rst = 0;

    // Reset then stream 1,2,3.
    in_valid = 1; out_ready = 1; in_payload = 32'h1;
    @(negedge clk); chk("stream_first_empty", {31'd0, out_valid1}, 0);
    tick(); in_payload = 32'h2;
    @(negedge clk); chk("stream_p1", out_payload1, 32'h1); chk("stream_occ", {30'd0, occupancy1}, 1);
    tick(); in_payload = 32'h3;
    @(negedge clk); chk("stream_p2", out_payload1, 32'h2);
    tick(); in_valid = 0;
    @(negedge clk); chk("stream_p3", out_payload1, 32'h3); chk("stream_v3", {31'd0, out_valid1}, 1);
    tick();
    @(negedge clk); chk("stream_drained", {31'd0, out_valid1}, 0);

    // Backpressure.
    out_ready = 0; in_valid = 1; in_payload = 32'hA;
    tick(); in_payload = 32'hB;
    @(negedge clk); chk("bp_occ1", {30'd0, occupancy1}, 1); chk("bp_ready1", {31'd0, in_ready1}, 1);
    tick(); in_payload = 32'hC;
    @(negedge clk); chk("bp_occ2", {30'd0, occupancy1}, 2); chk("bp_ready0", {31'd0, in_ready1}, 0);
    tick();
    @(negedge clk); chk("bp_hold_occ", {30'd0, occupancy1}, 2); chk("bp_hold_p", out_payload1, 32'hA);

    // Stall with two entries held.
    stall = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_occ", {30'd0, occupancy1}, 2);
      chk("stall_p", out_payload1, 32'hA);
      chk("stall_ready", {31'd0, in_ready1}, 0);
      tick();
    end
    stall = 0;
    @(negedge clk); chk("drain_a", out_payload1, 32'hA);
    tick();
    @(negedge clk); chk("drain_b", out_payload1, 32'hB); chk("drain_occ", {30'd0, occupancy1}, 1);
    tick(); in_valid = 0;
    @(negedge clk); chk("drain_c", out_payload1, 32'hC);
    tick();
    @(negedge clk); chk("drain_empty", {31'd0, out_valid1}, 0);

    // Flush with simultaneous push.
    out_ready = 0; in_valid = 1; in_payload = 32'hE;
    tick(); in_payload = 32'hF;
    tick(); flush = 1; in_payload = 32'hD;
    @(negedge clk); chk("flush_ready", {31'd0, in_ready1}, 0); chk("flush_occ_pre", {30'd0, occupancy1}, 2);
    tick(); flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk); chk("flush_valid", {31'd0, out_valid1}, 0); chk("flush_occ", {30'd0, occupancy1}, 0);
    tick();
    @(negedge clk); chk("flush_no_d", {31'd0, out_valid1}, 0);

    // Single-register mode with toggling out_ready.
    in_valid = 1; in_payload = 32'h20; out_ready = 1;
    tick(); in_payload = 32'h21;
    pat = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i][0];
      @(negedge clk);
      chk("s0_ready_mirror", {31'd0, in_ready0}, pat[i]);
      chk("s0_occ", {30'd0, occupancy0}, 1);
      tick();
      if (pat[i] != 0) in_payload = in_payload + 1;
    end
    in_valid = 0; out_ready = 1;
    tick(); tick();

    // Reset mid-operation.
    out_ready = 0; in_valid = 1; in_payload = 32'h30;
    tick(); in_payload = 32'h31;
    tick();
    @(negedge clk); chk("rmid_occ2", {30'd0, occupancy1}, 2);
    rst = 1; in_valid = 0;
    tick(); rst = 0;
    @(negedge clk);
    chk("rmid_valid", {31'd0, out_valid1}, 0);
    chk("rmid_occ", {30'd0, occupancy1}, 0);
    chk("rmid_payload", out_payload1, 32'h0);
    chk("rmid_ready", {31'd0, in_ready1}, 1);
    in_valid = 1; in_payload = 32'h40;
    tick(); in_valid = 0;
    @(negedge clk); chk("rmid_push_v", {31'd0, out_valid1}, 1); chk("rmid_push_p", out_payload1, 32'h40);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      stall      = ($urandom_range(0, 5) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 1) != 0);
      in_payload = $urandom;
      tick();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
